bram_port_ctrl: RTL and testbench

- Request/response front-end that drives one port (A or B) of the 1024x36 true-dual-port block RAM wrapper.
- Converts a valid/ready request stream (read or write) into single-cycle port strobes.
- Captures the RAM's 1-cycle-latency read data into a response FIFO with valid/ready backpressure.
- Guarantees no read data is lost: reads are only issued when response space is reserved (credit scheme).

---
 rtl/bram_port_pkg.sv | 24 ++
 rtl/bram_rsp_fifo.sv | 56 +++++
 rtl/bram_port_ctrl.sv | 117 +++++++++++
 tb/tb_bram_port_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_pkg.sv
// Shared constants and types for the block-RAM port controller.
// The optional write-ack path is enabled with BRAM_PORT_CTRL_WRITE_ACK_EN.
package bram_port_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 36;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bram_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              is_write;
    } bram_rsp_t;

    // Occupancy counter width: must represent the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Small synchronous FIFO holding RAM read responses; head is read straight
// from register storage so it stays stable while the consumer stalls.
module bram_rsp_fifo #(
    parameter  int W     = 36,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     mem_q [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bram_port_ctrl.sv
// Valid/ready front-end for one block-RAM port with credit-protected read responses.
// Define BRAM_PORT_CTRL_WRITE_ACK_EN to also return in-order write acknowledgements.
module bram_port_ctrl #(
    parameter int ADDR_W    = bram_port_pkg::ADDR_W,
    parameter int DATA_W    = bram_port_pkg::DATA_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
    output logic              rsp_is_write,
`endif
    output logic              bram_en,
    output logic              bram_writeEn,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_dataIn,
    input  logic [DATA_W-1:0] bram_dataOut
);
    import bram_port_pkg::*;

    localparam int CNT_W = cnt_width(RSP_DEPTH);
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic               fire;
    logic               push;
    logic               pop;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credits_used;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
    logic               inflight_wr_q, inflight_wr_d;
`endif

    // Every issued request holds a credit until its slot in the FIFO is freed,
    // so the RAM's fixed-latency read data always has somewhere to land.
    always_comb begin
        credits_used = {1'b0, count} + (CNT_W+1)'(inflight_q);
        req_ready    = reset_n & (credits_used < (CNT_W+1)'(RSP_DEPTH));
        fire         = req_valid & req_ready;
    end

    always_comb begin
        bram_en      = fire;
        bram_writeEn = fire & req_write;
        bram_addr    = req_addr;
        bram_dataIn  = req_data;
    end

`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
    always_comb begin
        inflight_d    = fire;
        inflight_wr_d = fire & req_write;
        push_entry    = {(inflight_wr_q ? {DATA_W{1'b0}} : bram_dataOut), inflight_wr_q};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q    <= 1'b0;
            inflight_wr_q <= 1'b0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_wr_q <= inflight_wr_d;
        end
    end

    assign rsp_data     = head_entry[ENTRY_W-1:1];
    assign rsp_is_write = head_entry[0];
`else
    always_comb begin
        inflight_d = fire & ~req_write;
        push_entry = bram_dataOut;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign rsp_data = head_entry;
`endif

    // RAM output is valid exactly one cycle after the strobe: capture it then.
    assign push      = inflight_q;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;

    bram_rsp_fifo #(
        .W     (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (count)
    );

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Directed bench for bram_port_ctrl with a behavioural RAM and an in-order response model.
// Honours BRAM_PORT_CTRL_WRITE_ACK_EN when defined.
module tb_bram_port_ctrl;

    localparam int AW    = bram_port_pkg::ADDR_W;
    localparam int DW    = bram_port_pkg::DATA_W;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
    logic          rsp_is_write;
`endif
    logic          bram_en;
    logic          bram_writeEn;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dataIn;
    logic [DW-1:0] bram_dataOut = '0;

    always #5 clock = ~clock;

    bram_port_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
        .rsp_is_write (rsp_is_write),
`endif
        .bram_en      (bram_en),
        .bram_writeEn (bram_writeEn),
        .bram_addr    (bram_addr),
        .bram_dataIn  (bram_dataIn),
        .bram_dataOut (bram_dataOut)
    );

    // Behavioural 1024x36 RAM port, preloaded with addr*3, one-cycle read latency.
    logic [DW-1:0] ram [1024];
    bit            ram_init = 1'b0;
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= DW'(i * 3);
            ram_init <= 1'b1;
        end else if (bram_en) begin
            bram_dataOut <= ram[bram_addr];
            if (bram_writeEn) ram[bram_addr] <= bram_dataIn;
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          iw;
        int            rdy;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          iw;
        int            cyc;
    } rlog_t;

    exp_t          q[$];
    rlog_t         rsp_log[$];
    int            fire_log[$];
    logic [DW-1:0] mdl_mem [1024];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted request not yet consumed holds a credit;
    // a response becomes visible two cycles after its request fired.
    logic exp_ready, exp_valid, m_fire, act_iw;
    always @(negedge clock) begin
        cyc++;
        if (cyc == 1) begin
            for (int i = 0; i < 1024; i++) mdl_mem[i] = DW'(i * 3);
        end
        if (!reset_n) begin
            q.delete();
            chk("reset_req_ready", req_ready, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_bram_en", bram_en, 0);
            chk("reset_bram_we", bram_writeEn, 0);
        end else begin
            exp_ready = (q.size() < DEPTH);
            exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("req_ready", req_ready, exp_ready);
            chk("rsp_valid", rsp_valid, exp_valid);
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
            act_iw = rsp_is_write;
`else
            act_iw = 1'b0;
`endif
            if (exp_valid) begin
                chk("rsp_data", rsp_data, q[0].data);
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
                chk("rsp_is_write", rsp_is_write, q[0].iw);
`endif
            end
            m_fire = req_valid && req_ready;
            chk("bram_en", bram_en, m_fire);
            chk("bram_writeEn", bram_writeEn, m_fire && req_write);
            if (m_fire) begin
                chk("bram_addr", bram_addr, req_addr);
                if (req_write) chk("bram_dataIn", bram_dataIn, req_data);
            end
            if (exp_valid && rsp_ready) begin
                rsp_log.push_back('{rsp_data, act_iw, cyc});
                void'(q.pop_front());
            end
            if (m_fire) begin
                fire_log.push_back(cyc);
                if (!req_write) begin
                    q.push_back('{mdl_mem[req_addr], 1'b0, cyc + 2});
                end else begin
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
                    q.push_back('{'0, 1'b1, cyc + 2});
`endif
                    mdl_mem[req_addr] = req_data;
                end
            end
            chk("no_overflow", q.size() <= DEPTH, 1);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        for (int t = 0; t < 50 && !done; t++) begin
            if (req_ready) done = 1'b1;
            step();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: addr %0d never accepted, expected acceptance within 50 cycles", a);
        end
    endtask

    task automatic clear_logs();
        rsp_log.delete();
        fire_log.delete();
    endtask

    int a;
    int off;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        #1;
        chk("post_reset_ready", req_ready, 1);
        chk("post_reset_valid", rsp_valid, 0);
        step();

        // Write then read the same address; the read must see the new data.
        rsp_ready = 1'b1;
        clear_logs();
        do_req(1'b1, 10'd5, 36'h123456789);
        do_req(1'b0, 10'd5, '0);
        do_req(1'b1, 10'd5, 36'd15);
        idle(6);
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
        off = 1;
        chk("t1_rsp_count", rsp_log.size(), 3);
`else
        off = 0;
        chk("t1_rsp_count", rsp_log.size(), 1);
`endif
        if (rsp_log.size() > off && fire_log.size() > 1) begin
            chk("t1_rsp_data", rsp_log[off].data, 36'h123456789);
            chk("t1_latency", rsp_log[off].cyc - fire_log[1], 2);
        end

        // Backpressure: only DEPTH reads accepted while the consumer stalls.
        clear_logs();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        a = 0;
        for (int t = 0; t < 10; t++) begin
            req_addr = AW'(a);
            if (req_ready) a++;
            step();
        end
        chk("t2_fires_stalled", fire_log.size(), 4);
        chk("t2_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        for (int t = 0; t < 60 && a < 8; t++) begin
            req_addr = AW'(a);
            if (req_ready) a++;
            step();
        end
        idle(8);
        chk("t2_rsp_count", rsp_log.size(), 8);
        for (int i = 0; i < 8 && i < rsp_log.size(); i++) begin
            chk("t2_rsp_order", rsp_log[i].data, 64'(i * 3));
        end

        // Sustained throughput: one read per cycle, one response per cycle.
        clear_logs();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int i = 0; i < 100; i++) begin
            req_addr = AW'(100 + i);
            step();
        end
        idle(6);
        chk("t3_fire_count", fire_log.size(), 100);
        chk("t3_rsp_count", rsp_log.size(), 100);
        if (fire_log.size() == 100 && rsp_log.size() == 100) begin
            chk("t3_fire_span", fire_log[99] - fire_log[0], 99);
            chk("t3_rsp_span", rsp_log[99].cyc - rsp_log[0].cyc, 99);
            chk("t3_fill_latency", rsp_log[0].cyc - fire_log[0], 2);
            chk("t3_last_data", rsp_log[99].data, 64'(199 * 3));
        end

        // Reset while two entries are queued and a third read is in flight.
        clear_logs();
        rsp_ready = 1'b0;
        do_req(1'b0, 10'd20, '0);
        do_req(1'b0, 10'd21, '0);
        do_req(1'b0, 10'd22, '0);
        req_valid = 1'b0;
        chk("t4_valid_before_reset", rsp_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("t4_valid_in_reset", rsp_valid, 0);
        chk("t4_ready_in_reset", req_ready, 0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("t4_ready_after", req_ready, 1);
        chk("t4_valid_after", rsp_valid, 0);
        clear_logs();
        rsp_ready = 1'b1;
        repeat (5) step();
        chk("t4_no_stale_rsp", rsp_log.size(), 0);

        // Address extremes and pointer wrap over 3*DEPTH reads with stalls.
        clear_logs();
        do_req(1'b1, 10'd1023, 36'hFEDCBA987);
        for (int k = 0; k < 3 * DEPTH; k++) begin
            rsp_ready = (k % 3 != 0);
            do_req(1'b0, (k % 2 == 0) ? AW'(1023 - k / 2) : AW'(k / 2), '0);
        end
        rsp_ready = 1'b1;
        idle(10);
`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
        off = 1;
`else
        off = 0;
`endif
        chk("t5_rsp_count", rsp_log.size(), 3 * DEPTH + off);
        if (rsp_log.size() >= off + 3) begin
            chk("t5_addr1023", rsp_log[off].data, 36'hFEDCBA987);
            chk("t5_addr0", rsp_log[off + 1].data, 0);
            chk("t5_addr1022", rsp_log[off + 2].data, 64'(1022 * 3));
        end

`ifdef BRAM_PORT_CTRL_WRITE_ACK_EN
        // Write acks interleave with read data in request order.
        clear_logs();
        rsp_ready = 1'b1;
        do_req(1'b1, 10'd7, 36'hABC);
        do_req(1'b0, 10'd7, '0);
        do_req(1'b1, 10'd8, 36'h55);
        idle(6);
        chk("t6_rsp_count", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            chk("t6_iw0", rsp_log[0].iw, 1);
            chk("t6_iw1", rsp_log[1].iw, 0);
            chk("t6_iw2", rsp_log[2].iw, 1);
            chk("t6_data0", rsp_log[0].data, 0);
            chk("t6_data1", rsp_log[1].data, 36'hABC);
            chk("t6_data2", rsp_log[2].data, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
